// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: RV32I fetch sequencer; owns the PC, issues one imem request at a time, presents fetched words to decode
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  output logic [31:0] if_instr,
  output logic        misalign_pulse
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, if_pcplus4_q, if_pcplus4_d, if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d, misalign_q, misalign_d;
  logic [31:0] redir_pc;
  assign redir_pc = {redirect_pc[31:2], 2'b00};
  always_comb begin
    state_d      = state_q;
    pc_d         = redirect_valid ? redir_pc : pc_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_pcplus4_d = if_pcplus4_q;
    if_instr_d   = if_instr_q;
    misalign_d   = redirect_valid && |redirect_pc[1:0];
    case (state_q)
      BOOT:  state_d = REQ;
      REQ:   if (imem_req_ready) state_d = redirect_valid ? DRAIN : WAIT;
      WAIT:
        if (redirect_valid) state_d = imem_rsp_valid ? REQ : DRAIN;
        else if (imem_rsp_valid) begin
          if_valid_d   = 1'b1;
          if_pc_d      = pc_q;
          if_pcplus4_d = pc_q + 32'd4;
          if_instr_d   = imem_rsp_data;
          pc_d         = pc_q + 32'd4;
          state_d      = HOLD;
        end
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      HOLD:
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0;
      if_pcplus4_q <= 32'h4;
      if_instr_q   <= 32'h0000_0013;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_pcplus4_q <= if_pcplus4_d;
      if_instr_q   <= if_instr_d;
      misalign_q   <= misalign_d;
    end
  end
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_pcplus4     = if_pcplus4_q;
  assign if_instr       = if_instr_q;
  assign misalign_pulse = misalign_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed cycle-by-cycle vectors for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, if_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic        imem_req_valid, if_valid, misalign_pulse;
  logic [31:0] imem_req_addr, if_pc, if_pcplus4, if_instr;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  fetch_pc_ctrl #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_pcplus4(if_pcplus4),
    .if_instr(if_instr), .misalign_pulse(misalign_pulse)
  );
  typedef struct {
    logic rdv; logic [31:0] rdpc; logic rqr; logic rsv; logic [31:0] rsd; logic ifr;
    logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc; logic [31:0] ip4; logic [31:0] instr; logic mis;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic rdv, logic [31:0] rdpc, logic rqr, logic rsv, logic [31:0] rsd, logic ifr,
                              logic rv, logic [31:0] addr, logic iv, logic [31:0] ipc, logic [31:0] ip4,
                              logic [31:0] instr, logic mis);
    vec_t v;
    v.rdv = rdv; v.rdpc = rdpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ifr = ifr;
    v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ip4 = ip4; v.instr = instr; v.mis = mis;
    return v;
  endfunction
  task automatic check(input string name, input vec_t v);
    tests++;
    if ({imem_req_valid, imem_req_addr, if_valid, if_pc, if_pcplus4, if_instr, misalign_pulse} !==
        {v.rv, v.addr, v.iv, v.ipc, v.ip4, v.instr, v.mis}) begin
      fails++;
      $display("FAIL %s: got rv=%0b addr=%h iv=%0b pc=%h pc4=%h instr=%h mis=%0b, want rv=%0b addr=%h iv=%0b pc=%h pc4=%h instr=%h mis=%0b",
               name, imem_req_valid, imem_req_addr, if_valid, if_pc, if_pcplus4, if_instr, misalign_pulse,
               v.rv, v.addr, v.iv, v.ipc, v.ip4, v.instr, v.mis);
    end
  endtask
  task automatic step(input string name, input vec_t v);
    check(name, v);
    redirect_valid = v.rdv; redirect_pc = v.rdpc; imem_req_ready = v.rqr;
    imem_rsp_valid = v.rsv; imem_rsp_data = v.rsd; if_ready = v.ifr;
    @(negedge clk);
  endtask
  initial begin
    //                rdv rdpc          rqr rsv rsd           ifr   rv addr          iv ipc           ip4           instr         mis
    vecs.push_back(mk(0, 0,             0, 0, 0,             0,    0, 32'h100,      0, 32'h0,        32'h4,        32'h13,       0)); // BOOT
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h100,      0, 32'h0,        32'h4,        32'h13,       0)); // REQ 100
    vecs.push_back(mk(0, 0,             0, 1, 32'hA0,        0,    0, 32'h100,      0, 32'h0,        32'h4,        32'h13,       0)); // WAIT
    vecs.push_back(mk(0, 0,             0, 0, 0,             1,    0, 32'h104,      1, 32'h100,      32'h104,      32'hA0,       0)); // HOLD
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h104,      0, 32'h100,      32'h104,      32'hA0,       0)); // REQ 104
    vecs.push_back(mk(0, 0,             0, 1, 32'hA1,        0,    0, 32'h104,      0, 32'h100,      32'h104,      32'hA0,       0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,           1, 1, 32'hBAD,       0,    0, 32'h108,      1, 32'h104,      32'h108,      32'hA1,       0)); // stall
    vecs.push_back(mk(0, 0,             0, 0, 0,             1,    0, 32'h108,      1, 32'h104,      32'h108,      32'hA1,       0));
    vecs.push_back(mk(0, 0,             0, 0, 0,             0,    1, 32'h108,      0, 32'h104,      32'h108,      32'hA1,       0)); // REQ not ready
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h108,      0, 32'h104,      32'h108,      32'hA1,       0));
    vecs.push_back(mk(1, 32'h200,       0, 0, 0,             0,    0, 32'h108,      0, 32'h104,      32'h108,      32'hA1,       0)); // redirect in WAIT
    vecs.push_back(mk(0, 0,             0, 1, 32'hBAD,       0,    0, 32'h200,      0, 32'h104,      32'h108,      32'hA1,       0)); // DRAIN
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h200,      0, 32'h104,      32'h108,      32'hA1,       0));
    vecs.push_back(mk(0, 0,             0, 1, 32'hA2,        0,    0, 32'h200,      0, 32'h104,      32'h108,      32'hA1,       0));
    vecs.push_back(mk(0, 0,             0, 0, 0,             1,    0, 32'h204,      1, 32'h200,      32'h204,      32'hA2,       0));
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h204,      0, 32'h200,      32'h204,      32'hA2,       0));
    vecs.push_back(mk(1, 32'h300,       0, 1, 32'hBAD,       0,    0, 32'h204,      0, 32'h200,      32'h204,      32'hA2,       0)); // redirect+rsp
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h300,      0, 32'h200,      32'h204,      32'hA2,       0));
    vecs.push_back(mk(0, 0,             0, 1, 32'hA3,        0,    0, 32'h300,      0, 32'h200,      32'h204,      32'hA2,       0));
    vecs.push_back(mk(1, 32'h300,       0, 0, 0,             1,    0, 32'h304,      1, 32'h300,      32'h304,      32'hA3,       0)); // redirect in HOLD
    vecs.push_back(mk(1, 32'h402,       0, 0, 0,             0,    1, 32'h300,      0, 32'h300,      32'h304,      32'hA3,       0)); // misaligned, REQ stall
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h400,      0, 32'h300,      32'h304,      32'hA3,       1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0,             0,    0, 32'h400,      0, 32'h300,      32'h304,      32'hA3,       0));
    vecs.push_back(mk(0, 0,             0, 1, 32'hBAD,       0,    0, 32'hFFFF_FFFC,0, 32'h300,      32'h304,      32'hA3,       0));
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'hFFFF_FFFC,0, 32'h300,      32'h304,      32'hA3,       0));
    vecs.push_back(mk(0, 0,             0, 1, 32'hA4,        0,    0, 32'hFFFF_FFFC,0, 32'h300,      32'h304,      32'hA3,       0));
    vecs.push_back(mk(0, 0,             0, 0, 0,             1,    0, 32'h0,        1, 32'hFFFF_FFFC,32'h0,        32'hA4,       0)); // wrap
    vecs.push_back(mk(0, 0,             1, 0, 0,             0,    1, 32'h0,        0, 32'hFFFF_FFFC,32'h0,        32'hA4,       0));
    vecs.push_back(mk(0, 0,             0, 0, 0,             0,    0, 32'h0,        0, 32'hFFFF_FFFC,32'h0,        32'hA4,       0)); // WAIT
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);
    #2 rst_n = 0;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h0, 32'h4, 32'h13, 0));
    @(negedge clk);
    rst_n = 1;
    step("late_rsp_boot", mk(0, 0, 0, 1, 32'hBAD, 0, 0, 32'h100, 0, 32'h0, 32'h4, 32'h13, 0));
    step("late_rsp_req",  mk(0, 0, 0, 1, 32'hBAD, 0, 1, 32'h100, 0, 32'h0, 32'h4, 32'h13, 0));
    step("req_redirect",  mk(1, 32'h500, 1, 0, 0, 0, 1, 32'h100, 0, 32'h0, 32'h4, 32'h13, 0));
    step("drain_500",     mk(0, 0, 0, 1, 32'hBAD, 0, 0, 32'h500, 0, 32'h0, 32'h4, 32'h13, 0));
    step("req_500",       mk(0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 32'h0, 32'h4, 32'h13, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
